// File: rtl/sr_ctrl_pkg.sv
// sr_ctrl_pkg: shared state encoding and default sizes for the SR bank
// controller and its round-robin arbiter.
package sr_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 8;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick. Starting at i_ptr and wrapping
// around, the first asserted request wins; the result is returned both as a
// one-hot grant vector and as a binary index.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [PW-1:0]   o_idx
);

  logic          w_found;
  logic [PW-1:0] w_cand;

  // Scan candidates in priority order ptr, ptr+1, ... and keep the first hit.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves it unassigned and infers a latch.
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = PW'((int'(i_ptr) + k) % NREQ);
      if (!w_found && i_req[w_cand]) begin
        w_found       = 1'b1;
        o_gnt[w_cand] = 1'b1;
        o_idx         = w_cand;
      end
    end
  end

endmodule

// File: rtl/sr_bank_ctrl.sv
// sr_bank_ctrl: sequencing controller and round-robin arbiter for a bank of
// clocked SR flip-flops shared by NREQ requesters. Each granted operation
// drives S/R for exactly one clock; bits requested as both set and clear are
// masked off, so S & R is always zero, and are reported through err.
// Optional build macro SR_CHECK_EN: adds a CHECK state that reads q back and
// flags a mismatch against the expected bank value. Without it, q is unused
// and err reports conflicts only.
module sr_bank_ctrl
  import sr_ctrl_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_set,
  input  logic [NREQ*WIDTH-1:0] req_clr,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      S,
  output logic [WIDTH-1:0]      R,
  input  logic [WIDTH-1:0]      q,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int PW = $clog2(NREQ);

  state_t           r_state, w_state_nxt;
  logic [PW-1:0]    r_ptr, w_ptr_nxt;
  logic [PW-1:0]    r_idx;
  logic [NREQ-1:0]  r_gnt;
  logic [WIDTH-1:0] r_conf, r_set_eff, r_clr_eff;
  logic             r_done, r_err;
  logic             w_done_nxt, w_err_nxt, w_load;

  logic [NREQ-1:0]  w_arb_gnt;
  logic [PW-1:0]    w_arb_idx;
  logic [WIDTH-1:0] w_set, w_clr, w_conf, w_set_eff, w_clr_eff;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_gnt (w_arb_gnt),
    .o_idx (w_arb_idx)
  );

  // Masks of the requester the arbiter would grant this cycle.
  assign w_set     = req_set[w_arb_idx*WIDTH +: WIDTH];
  assign w_clr     = req_clr[w_arb_idx*WIDTH +: WIDTH];
  assign w_conf    = w_set & w_clr;
  assign w_set_eff = w_set & ~w_conf;
  assign w_clr_eff = w_clr & ~w_conf;

`ifdef SR_CHECK_EN
  logic [WIDTH-1:0] r_exp;
  logic [WIDTH-1:0] w_exp;
  assign w_exp = (q & ~w_clr_eff) | w_set_eff;
`else
  logic w_unused_q;
  assign w_unused_q = ^q;
`endif

  // State, rr pointer and completion flags; reset drops any pending op.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
    if (!rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Capture the granted masks and expected value when an op is accepted.
  always_ff @(posedge clk) begin
    // NOTE: these datapath registers carry no reset; they are always loaded before a state that reads them, and outputs are gated by state.
    if (w_load) begin
      r_idx     <= w_arb_idx;
      r_gnt     <= w_arb_gnt;
      r_conf    <= w_conf;
      r_set_eff <= w_set_eff;
      r_clr_eff <= w_clr_eff;
`ifdef SR_CHECK_EN
      r_exp     <= w_exp;
`endif
    end
  end

  // Next state, pointer advance, completion flags and bank drive per state.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_load      = 1'b0;
    gnt         = '0;
    S           = '0;
    R           = '0;
    case (r_state)
      IDLE: begin
        if (|req) begin
          w_load      = 1'b1;
          w_state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        gnt       = r_gnt;
        S         = r_set_eff;
        R         = r_clr_eff;
        w_ptr_nxt = (int'(r_idx) == NREQ - 1) ? '0 : r_idx + 1'b1;
`ifdef SR_CHECK_EN
        w_state_nxt = CHECK;
`else
        w_state_nxt = IDLE;
        w_done_nxt  = 1'b1;
        w_err_nxt   = |r_conf;
`endif
      end
`ifdef SR_CHECK_EN
      CHECK: begin
        w_state_nxt = IDLE;
        w_done_nxt  = 1'b1;
        w_err_nxt   = (|r_conf) | (q != r_exp);
      end
`endif
      default: w_state_nxt = IDLE;
    endcase
  end

  assign busy = (r_state != IDLE);
  assign done = r_done;
  assign err  = r_err;

endmodule

// File: tb/tb_sr_bank_ctrl.sv
// tb_sr_bank_ctrl: self-checking bench for sr_bank_ctrl. Contains a model of
// the SR flip-flop bank (driven by the DUT's S/R) and a reference model of the
// arbitration and masking rules. Works with or without SR_CHECK_EN.
module tb_sr_bank_ctrl;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                        clk;
  logic                        rst;
  logic [NREQ-1:0]             req;
  logic [NREQ-1:0][WIDTH-1:0]  m_set;
  logic [NREQ-1:0][WIDTH-1:0]  m_clr;
  logic [NREQ*WIDTH-1:0]       req_set;
  logic [NREQ*WIDTH-1:0]       req_clr;
  logic [NREQ-1:0]             gnt;
  logic [WIDTH-1:0]            S;
  logic [WIDTH-1:0]            R;
  logic [WIDTH-1:0]            q;
  logic                        busy;
  logic                        done;
  logic                        err;

  // Bank model and readback override.
  logic [WIDTH-1:0] bank_q;
  logic             bank_ld;
  logic [WIDTH-1:0] bank_ld_val;
  logic             q_force_en;
  logic [WIDTH-1:0] q_force_val;

  // Reference-model state and counters.
  int               mptr;
  logic [WIDTH-1:0] mq;
  int               n_checks = 0;
  int               n_pass   = 0;
  int               n_fail   = 0;
  int               exp_done = 0;
  int               n_done   = 0;
  int               sr_viol  = 0;
  logic             mon_en;

  assign req_set = m_set;
  assign req_clr = m_clr;
  assign q       = q_force_en ? q_force_val : bank_q;

  sr_bank_ctrl #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .req_set (req_set),
    .req_clr (req_clr),
    .gnt     (gnt),
    .S       (S),
    .R       (R),
    .q       (q),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clocked SR bank: S sets, R clears, S=R=1 yields X.
  always @(posedge clk) begin
    if (bank_ld)              bank_q <= bank_ld_val;
    else if ((S & R) != '0)   bank_q <= 'x;
    else                      bank_q <= (bank_q & ~R) | S;
  end

  // Cycle monitor: forbidden S/R overlap and done pulse count.
  always @(negedge clk) begin
    if (mon_en) begin
      if ((S & R) !== '0) sr_viol <= sr_viol + 1;
      if (done === 1'b1)  n_done  <= n_done + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Round-robin rule: first requester at or after p, wrapping.
  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return 0;
  endfunction

  task automatic preload(input logic [WIDTH-1:0] v);
    bank_ld     = 1'b1;
    bank_ld_val = v;
    tick();
    bank_ld     = 1'b0;
    mq          = v;
  endtask

  // One full operation, entered with the DUT idle and req nonzero.
  // hold keeps req asserted after grant; fq forces q to 0 after DRIVE.
  task automatic serve_one(input bit hold, input bit fq);
    int               j;
    logic [WIDTH-1:0] s, c, se, ce, eq;
    logic             ee;
    j  = pick(req, mptr);
    s  = m_set[j];
    c  = m_clr[j];
    se = s & ~c;
    ce = c & ~s;
    ee = |(s & c);
    eq = (mq | se) & ~ce;
    tick();
    check("gnt", 32'(gnt), 32'(1 << j));
    check("S_drive", 32'(S), 32'(se));
    check("R_drive", 32'(R), 32'(ce));
    check("busy_drive", 32'(busy), 32'd1);
    check("done_drive", 32'(done), 32'd0);
    if (!hold) req[j] = 1'b0;
    mptr = (j + 1) % NREQ;
    if (fq) begin
      q_force_en  = 1'b1;
      q_force_val = '0;
    end
`ifdef SR_CHECK_EN
    tick();
    check("S_check", 32'(S), 32'd0);
    check("R_check", 32'(R), 32'd0);
    check("gnt_check", 32'(gnt), 32'd0);
    check("busy_check", 32'(busy), 32'd1);
    check("done_check", 32'(done), 32'd0);
    if (fq) ee = ee | (q_force_val != eq);
`endif
    tick();
    check("done", 32'(done), 32'd1);
    check("err", 32'(err), 32'(ee));
    check("busy_idle", 32'(busy), 32'd0);
    exp_done++;
    if (fq) begin
      q_force_en = 1'b0;
      #1;
    end
    check("bank_q", 32'(q), 32'(eq));
    mq = eq;
  endtask

  initial begin
    rst         = 1'b0;
    req         = '0;
    m_set       = '0;
    m_clr       = '0;
    bank_ld     = 1'b1;
    bank_ld_val = '0;
    q_force_en  = 1'b0;
    q_force_val = '0;
    mptr        = 0;
    mq          = '0;
    mon_en      = 1'b0;

    // Reset values.
    repeat (3) tick();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_S", 32'(S), 32'd0);
    check("rst_R", 32'(R), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst     = 1'b1;
    bank_ld = 1'b0;
    mon_en  = 1'b1;
    tick();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("idle_q", 32'(q), 32'd0);

    // First op after reset: set 0x0F on requester 0.
    req = 4'b0001; m_set[0] = 8'h0F; m_clr[0] = 8'h00;
    serve_one(1'b0, 1'b0);

    // All-zero masks still complete, no error.
    req = 4'b0100; m_set[2] = 8'h00; m_clr[2] = 8'h00;
    serve_one(1'b0, 1'b0);

    // Conflict: set F0 / clr 30 on bank 3C -> S=C0, R=0, Q=FC, err.
    preload(8'h3C);
    req = 4'b0010; m_set[1] = 8'hF0; m_clr[1] = 8'h30;
    serve_one(1'b0, 1'b0);

    // Readback mismatch: q forced to 0 after DRIVE of set=01.
    preload(8'h00);
    req = 4'b1000; m_set[3] = 8'h01; m_clr[3] = 8'h00;
    serve_one(1'b0, 1'b1);

    // Reset in the DRIVE cycle: op dropped, no done, pointer back to 0.
    req = 4'b0100; m_set[2] = 8'hA0; m_clr[2] = 8'h05;
    tick();
    check("mid_gnt", 32'(gnt), 32'b0100);
    check("mid_S", 32'(S), 32'hA0);
    rst = 1'b0;
    req = '0;
    tick();
    check("mid_rst_S", 32'(S), 32'd0);
    check("mid_rst_R", 32'(R), 32'd0);
    check("mid_rst_gnt", 32'(gnt), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    mq   = (mq & ~8'h05) | 8'hA0;
    rst  = 1'b1;
    mptr = 0;
    tick();
    check("mid_after_done", 32'(done), 32'd0);
    check("mid_bank_q", 32'(q), 32'(mq));

    // Contention: all four held -> 0001, 0010, 0100, 1000, 0001.
    for (int i = 0; i < NREQ; i++) begin
      m_set[i] = 8'h01 << i;
      m_clr[i] = 8'h10 << i;
    end
    req = 4'b1111;
    for (int n = 0; n < 5; n++) serve_one(1'b1, 1'b0);
    req = '0;

    // Randomized ops against the model.
    for (int n = 0; n < 1000; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        m_set[i] = WIDTH'($urandom);
        m_clr[i] = WIDTH'($urandom & $urandom);
      end
      req = req | NREQ'($urandom_range(0, (1 << NREQ) - 1));
      if (req == '0) req[$urandom_range(0, NREQ - 1)] = 1'b1;
      serve_one(1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
    end
    while (req != '0) serve_one(1'b0, 1'b0);

    tick();
    tick();
    check("sr_invariant", 32'(sr_viol), 32'd0);
    check("done_count", 32'(n_done), 32'(exp_done));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sr_bank_ctrl.md
# sr_bank_ctrl

Sequencing controller and round-robin arbiter for a bank of WIDTH clocked SR flip-flops shared by NREQ requesters. Each requester submits set/clear bit masks. The block grants one requester at a time and drives the bank's S and R vectors for exactly one clock. The encoding it produces can never be S=R=1, the forbidden code that makes the flip-flop output X. With checking compiled in, it also reads the bank's Q back and reports a mismatch.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, number of SR flip-flops in the bank

Ports:
- clk  input  1  clock; all state updates on posedge
- rst  input  1  synchronous, active-low reset
- req  input  NREQ  request valid per requester; held until the matching gnt bit is seen
- req_set  input  NREQ*WIDTH  set mask; requester i uses bits [i*WIDTH +: WIDTH]
- req_clr  input  NREQ*WIDTH  clear mask; same slicing as req_set
- gnt  output  NREQ  one-hot grant; high for the DRIVE cycle only
- S  output  WIDTH  set vector to the bank
- R  output  WIDTH  reset vector to the bank
- q  input  WIDTH  bank Q readback
- busy  output  1  high whenever state is not IDLE
- done  output  1  one-cycle pulse when an operation completes
- err  output  1  valid with done; high on conflict or readback mismatch

## Operation
- **Reset values:** state IDLE, rr pointer 0, all outputs 0.
  - Reset applies at the next edge even mid-operation: S and R go to 0 and the pending op is dropped with no done.
  - The bank contents are not touched by reset.
- **IDLE**
  - If any req bit is set: pick the first set bit at or after the rr pointer, wrapping around.
  - Register the granted masks and the conflict mask conf = set & clr.
  - Compute effective masks: set_eff = set & ~conf, clr_eff = clr & ~conf.
  - Compute expected value: exp = (q & ~clr_eff) | set_eff.
  - Go to DRIVE.
- **DRIVE**
  - gnt[i]=1, S=set_eff, R=clr_eff.
  - Next state is CHECK, or IDLE when SR_CHECK_EN is undefined.
  - The rr pointer becomes (i+1) mod NREQ.
- **CHECK**
  - S=R=0.
  - Compare q against exp; the result is err_next = (|conf) | (q != exp).
  - Go to IDLE.
- **Completion:** done and err are registered. They pulse in the first IDLE cycle after completion; arbitration for the next op proceeds in that same cycle.
- **Conflicting bits:** a bit set in both masks drives S=R=0 on that bit, so the bank holds its value, and err is flagged.
- **All-zero masks:** a request with both masks 0 is still granted and completes with done=1, err=0.
- **Invariant:** (S & R) == 0 in every cycle.
- **Ownership:** only this block drives the bank; q is stable between grant and CHECK apart from the block's own DRIVE.

## Timing
- **Latency:** req sampled in IDLE at cycle 0; gnt, S, R in cycle 1; CHECK in cycle 2; done in cycle 3.
  - Without SR_CHECK_EN, done arrives in cycle 2.
- **Throughput:** one op per 3 cycles, or per 2 without checking.
- **Re-service:** a requester must drop req in the cycle after seeing gnt. A req still high at the next IDLE is served again, under normal rr priority.
- **Contention:** simultaneous requests are served in rr order starting from the pointer. No requester waits more than NREQ-1 ops.

## Configuration
- **SR_CHECK_EN defined:**
  - The CHECK state and readback compare are built.
  - err = conflict OR mismatch.
- **SR_CHECK_EN undefined:**
  - No CHECK state; q is unused.
  - err = conflict only.

## Structure
- **Package sr_ctrl_pkg:**
  - state enum {IDLE, DRIVE, CHECK}
  - default constants NREQ_DEF=4 and WIDTH_DEF=8
- **Sub-module rr_arbiter:** parameterised NREQ, combinational. Takes req and pointer; produces a one-hot grant and the granted index.
- **Top level:** sr_bank_ctrl contains the FSM, the mask registers, exp, and the pointer.

## Test plan
- **Reset:** after reset, req=0001, set0=8'h0F, clr0=0 -> gnt=0001 in cycle 1 with S=8'h0F, R=0; done=1, err=0 in cycle 3; bank Q=8'h0F.
- **Contention:** req=1111 held continuously -> grants 0001, 0010, 0100, 1000, 0001 in that order, 3 cycles apart.
- **Conflict:** set=8'hF0, clr=8'h30 with Q=8'h3C -> S=8'hC0, R=0; Q becomes 8'hFC; done with err=1.
- **Readback mismatch:** force bank q to 8'h00 after DRIVE of set=8'h01 -> err=1 (SR_CHECK_EN defined); err=0 when undefined, done one cycle earlier.
- **Reset mid-op:** rst low in the DRIVE cycle -> next cycle S=R=0, gnt=0, busy=0, no done pulse; pointer back to 0.
- **Invariant:** random masks for 1000 ops -> (S & R) never nonzero; every granted op produces exactly one done.
